// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the core datapath and the PC sequencer.
// Latency: none (wires only).
// Backpressure: stall is the only hold signal, driven by the core side.
interface pc_sequencer_if;
    logic        stall;
    logic [2:0]  pc_sel;
    logic [15:0] branch_lit;
    logic [31:0] jump_addr;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] imem_addr;
    logic        annul;
    logic        irq_taken;
    logic        spinning;

    modport slave (
        input  stall, pc_sel, branch_lit, jump_addr, irq,
        output pc, pc_plus4, imem_addr, annul, irq_taken, spinning
    );

    modport master (
        output stall, pc_sel, branch_lit, jump_addr, irq,
        input  pc, pc_plus4, imem_addr, annul, irq_taken, spinning
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection with supervisor rules, interrupt entry and spin detection.
// Latency: new PC one cycle after selection; pc_plus4/imem_addr/annul combinational.
// Backpressure: stall holds PC and spin count; pending interrupts are retained.
module pc_sequencer #(
    parameter logic [31:0] RESET_ADDR  = 32'd0,
    parameter logic [31:0] ILLOP_ADDR  = 32'd392,
    parameter logic [31:0] XADR_ADDR   = 32'd396,
    parameter int unsigned SPIN_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    localparam logic [31:0] RESET_VEC   = {1'b1, RESET_ADDR[30:2], 2'b00};
    localparam logic [31:0] ILLOP_VEC   = {1'b1, ILLOP_ADDR[30:2], 2'b00};
    localparam logic [31:0] XADR_VEC    = {1'b1, XADR_ADDR[30:2], 2'b00};
    localparam logic [7:0]  SPIN_THRESH = 8'(SPIN_CYCLES);

    logic [31:0] pc_q, pc_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        sync3_q, sync3_d;
    logic        irq_pending_q, irq_pending_d;
    logic        irq_taken_q, irq_taken_d;
    logic [7:0]  spin_cnt_q, spin_cnt_d;
    logic        spinning_q, spinning_d;

    logic [31:0] pc_plus4;
    logic [30:0] br_off;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic        take_irq;
    logic        irq_rise;
    logic        unused_jump_lsbs;

    assign unused_jump_lsbs = ^bus.jump_addr[1:0];

    always_comb begin
        pc_plus4   = {pc_q[31], pc_q[30:0] + 31'd4};
        br_off     = {{13{bus.branch_lit[15]}}, bus.branch_lit, 2'b00};
        branch_tgt = {pc_q[31], pc_plus4[30:0] + br_off};
        // A jump may drop into user mode but can never raise privilege.
        jump_tgt   = {pc_q[31] & bus.jump_addr[31], bus.jump_addr[30:2], 2'b00};
        take_irq   = irq_pending_q & ~pc_q[31] & ~bus.stall;
        irq_rise   = sync2_q & ~sync3_q;

        pc_d = pc_q;
        if (!bus.stall) begin
            if (take_irq) begin
                pc_d = XADR_VEC;
            end else begin
                case (bus.pc_sel)
                    3'd0:    pc_d = pc_plus4;
                    3'd1:    pc_d = branch_tgt;
                    3'd2:    pc_d = jump_tgt;
                    default: pc_d = ILLOP_VEC;
                endcase
            end
        end

        sync1_d       = bus.irq;
        sync2_d       = sync1_q;
        sync3_d       = sync2_q;
        irq_pending_d = (irq_pending_q & ~take_irq) | irq_rise;
        irq_taken_d   = take_irq;

        spin_cnt_d = spin_cnt_q;
        if (!bus.stall) begin
            if (pc_d == pc_q) begin
                spin_cnt_d = (spin_cnt_q == 8'hFF) ? spin_cnt_q : spin_cnt_q + 8'd1;
            end else begin
                spin_cnt_d = 8'd0;
            end
        end
        spinning_d = (spin_cnt_d >= SPIN_THRESH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_VEC;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            irq_pending_q <= 1'b0;
            irq_taken_q   <= 1'b0;
            spin_cnt_q    <= 8'd0;
            spinning_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            irq_pending_q <= irq_pending_d;
            irq_taken_q   <= irq_taken_d;
            spin_cnt_q    <= spin_cnt_d;
            spinning_q    <= spinning_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.imem_addr = {1'b0, pc_q[30:2], 2'b00};
    assign bus.annul     = take_irq;
    assign bus.irq_taken = irq_taken_q;
    assign bus.spinning  = spinning_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, branch/jump rules, spin, interrupts, wrap, reset.
// Latency: inputs change after a sample point; outputs sampled 1 ns after each rising edge.
// Backpressure: stall is exercised around interrupt entry and reset.
module tb_pc_sequencer;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_failed;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [15:0] lit, input logic [31:0] ja);
        bus.pc_sel     = sel;
        bus.branch_lit = lit;
        bus.jump_addr  = ja;
    endtask

    initial begin
        n_tests       = 0;
        n_failed      = 0;
        reset         = 1'b1;
        bus.stall     = 1'b0;
        bus.irq       = 1'b0;
        drive(3'd0, 16'd0, 32'd0);
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_pc", bus.pc, 32'h8000_0000);
        check("rst_pc_plus4", bus.pc_plus4, 32'h8000_0004);
        check("rst_imem", bus.imem_addr, 32'h0);
        check("rst_annul", {31'd0, bus.annul}, 32'd0);
        check("rst_irq_taken", {31'd0, bus.irq_taken}, 32'd0);
        check("rst_spinning", {31'd0, bus.spinning}, 32'd0);

        // Sequential fetch
        for (int i = 1; i <= 3; i++) begin
            step();
            check("seq_pc", bus.pc, 32'h8000_0000 + 32'(4 * i));
            check("seq_imem", bus.imem_addr, 32'(4 * i));
        end

        // Jump into user mode at 0x50, then branch -1 self-loop
        drive(3'd2, 16'd0, 32'h0000_0050);
        step();
        check("jmp_user_pc", bus.pc, 32'h0000_0050);
        drive(3'd1, 16'hFFFF, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("loop_pc", bus.pc, 32'h0000_0050);
            check("loop_spinning", {31'd0, bus.spinning}, (i >= 4) ? 32'd1 : 32'd0);
        end
        drive(3'd0, 16'd0, 32'd0);
        step();
        check("unspin_pc", bus.pc, 32'h0000_0054);
        check("unspin_spinning", {31'd0, bus.spinning}, 32'd0);

        // Positive branch offset: 0x54 + 4 + 3*4 = 0x64
        drive(3'd1, 16'd3, 32'd0);
        step();
        check("branch_fwd", bus.pc, 32'h0000_0064);

        // Supervisor jump keeps bit 31; user jump cannot set it
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(3'd2, 16'd0, 32'h8000_0010);
        step();
        check("sup_pc", bus.pc, 32'h8000_0010);
        drive(3'd2, 16'd0, 32'h8000_0078);
        step();
        check("sup_jump", bus.pc, 32'h8000_0078);
        drive(3'd2, 16'd0, 32'h0000_0010);
        step();
        check("user_pc", bus.pc, 32'h0000_0010);
        drive(3'd2, 16'd0, 32'h8000_0078);
        step();
        check("user_jump_refused", bus.pc, 32'h0000_0078);

        // Illegal op from user mode
        drive(3'd3, 16'd0, 32'd0);
        step();
        check("illop_pc", bus.pc, 32'h8000_0188);

        // User-mode interrupt; pending edge also preempts a simultaneous illop
        drive(3'd2, 16'd0, 32'h0000_0100);
        step();
        check("irq_user_pc", bus.pc, 32'h0000_0100);
        bus.irq = 1'b1;
        step();
        bus.irq = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.annul) break;
            check("irq_wait_taken", {31'd0, bus.irq_taken}, 32'd0);
            step();
        end
        check("irq_annul", {31'd0, bus.annul}, 32'd1);
        check("irq_hold_pc", bus.pc, 32'h0000_0100);
        drive(3'd3, 16'd0, 32'd0);
        step();
        check("irq_entry_pc", bus.pc, 32'h8000_018C);
        check("irq_taken_pulse", {31'd0, bus.irq_taken}, 32'd1);
        check("irq_annul_after", {31'd0, bus.annul}, 32'd0);
        drive(3'd0, 16'd0, 32'd0);
        step();
        check("irq_taken_one", {31'd0, bus.irq_taken}, 32'd0);
        check("irq_seq_after", bus.pc, 32'h8000_0190);

        // Interrupt held off by stall, taken on first unstalled edge
        drive(3'd2, 16'd0, 32'h0000_0100);
        step();
        bus.stall = 1'b1;
        bus.irq   = 1'b1;
        step();
        bus.irq   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_pc", bus.pc, 32'h0000_0100);
            check("stall_annul", {31'd0, bus.annul}, 32'd0);
            check("stall_taken", {31'd0, bus.irq_taken}, 32'd0);
        end
        bus.stall = 1'b0;
        drive(3'd0, 16'd0, 32'd0);
        #1;
        check("unstall_annul", {31'd0, bus.annul}, 32'd1);
        step();
        check("unstall_entry", bus.pc, 32'h8000_018C);
        check("unstall_taken", {31'd0, bus.irq_taken}, 32'd1);

        // Supervisor defers the interrupt until pc[31] drops
        drive(3'd2, 16'd0, 32'h8000_0020);
        step();
        bus.irq = 1'b1;
        step();
        bus.irq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("sup_defer_pc", bus.pc, 32'h8000_0020);
            check("sup_defer_annul", {31'd0, bus.annul}, 32'd0);
        end
        drive(3'd2, 16'd0, 32'h0000_0040);
        step();
        check("sup_exit_pc", bus.pc, 32'h0000_0040);
        check("sup_exit_annul", {31'd0, bus.annul}, 32'd1);
        drive(3'd0, 16'd0, 32'd0);
        step();
        check("deferred_entry", bus.pc, 32'h8000_018C);
        drive(3'd5, 16'd0, 32'd0);
        step();
        check("reserved_sel", bus.pc, 32'h8000_0188);

        // Address wrap keeps the supervisor bit as-is (user here)
        drive(3'd2, 16'd0, 32'h7FFF_FFFC);
        step();
        check("wrap_pre", bus.pc, 32'h7FFF_FFFC);
        check("wrap_plus4", bus.pc_plus4, 32'h0000_0000);
        drive(3'd0, 16'd0, 32'd0);
        step();
        check("wrap_pc", bus.pc, 32'h0000_0000);

        // Reset mid-stall with an interrupt pending
        drive(3'd2, 16'd0, 32'h0000_0040);
        step();
        check("pre_rst_pc", bus.pc, 32'h0000_0040);
        bus.stall = 1'b1;
        bus.irq   = 1'b1;
        step();
        bus.irq   = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        check("stall_rst_pc", bus.pc, 32'h8000_0000);
        reset     = 1'b0;
        bus.stall = 1'b0;
        drive(3'd2, 16'd0, 32'h0000_0040);
        step();
        drive(3'd0, 16'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("rst_cleared_annul", {31'd0, bus.annul}, 32'd0);
            step();
        end
        check("rst_cleared_pc", bus.pc, 32'h0000_004C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
